// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP add/sub datapath between N_REQ requesters.
// Each requester has a single credit; results return through a one-deep buffer per requester.
module fp_addsub_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 2,
    parameter int unsigned LAT   = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_op,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [N_REQ*WIDTH-1:0] resp_result,
    output logic                   dp_valid,
    output logic [WIDTH-1:0]       dp_a,
    output logic [WIDTH-1:0]       dp_b,
    output logic                   dp_op,
    input  logic [WIDTH-1:0]       dp_result,
    output logic [N_REQ-1:0]       busy,
    output logic [CNT_W-1:0]       ops_issued
);

    localparam int unsigned TAG_W = $clog2(N_REQ);
    localparam int unsigned CAND_W = TAG_W + 1;
    localparam int unsigned NSTG = LAT + 1;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [CAND_W-1:0] cand_t;

    // Architectural state
    logic [N_REQ-1:0]       busy_q, busy_d;
    logic [N_REQ-1:0]       resp_valid_q, resp_valid_d;
    logic [N_REQ*WIDTH-1:0] resp_result_q, resp_result_d;
    logic                   dp_valid_q, dp_valid_d;
    logic [WIDTH-1:0]       dp_a_q, dp_a_d;
    logic [WIDTH-1:0]       dp_b_q, dp_b_d;
    logic                   dp_op_q, dp_op_d;
    tag_t                   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       ops_q, ops_d;
    logic [NSTG-1:0]        pipe_vld_q, pipe_vld_d;
    tag_t                   pipe_tag_q [NSTG];

    // Arbitration signals
    logic [N_REQ-1:0] eligible;
    logic             grant_vld;
    tag_t             grant_tag;
    cand_t            cand;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_op;
    logic [N_REQ-1:0] consume;
    logic             ret_vld;
    tag_t             ret_tag;

    assign eligible = req_valid & ~busy_q;

    // Search from rr_ptr upward, wrapping; cand is one bit wider so the sum cannot overflow.
    always_comb begin
        grant_vld = 1'b0;
        grant_tag = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = cand_t'(rr_ptr_q) + cand_t'(k);
            if (cand >= cand_t'(N_REQ)) begin
                cand = cand - cand_t'(N_REQ);
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!grant_vld && cand == cand_t'(i) && eligible[i]) begin
                    grant_vld = 1'b1;
                    grant_tag = tag_t'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_vld && grant_tag == tag_t'(i)) begin
                req_ready[i] = 1'b1;
                sel_a        = req_a[i*WIDTH +: WIDTH];
                sel_b        = req_b[i*WIDTH +: WIDTH];
                sel_op       = req_op[i];
            end
        end
    end

    // Issue side: registered operands hold when nothing is accepted.
    always_comb begin
        dp_valid_d = grant_vld;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        dp_op_d    = dp_op_q;
        rr_ptr_d   = rr_ptr_q;
        ops_d      = ops_q;
        if (grant_vld) begin
            dp_a_d  = sel_a;
            dp_b_d  = sel_b;
            dp_op_d = sel_op;
            ops_d   = ops_q + CNT_W'(1);
            if (grant_tag == tag_t'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_tag + tag_t'(1);
            end
        end
    end

    assign pipe_vld_d = {pipe_vld_q[NSTG-2:0], grant_vld};
    assign ret_vld    = pipe_vld_q[NSTG-1];
    assign ret_tag    = pipe_tag_q[NSTG-1];
    assign consume    = resp_valid_q & resp_ready;

    // A requester's buffer can't be both consumed and refilled in one cycle: busy blocks reissue.
    always_comb begin
        busy_d        = busy_q & ~consume;
        resp_valid_d  = resp_valid_q & ~consume;
        resp_result_d = resp_result_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_vld && grant_tag == tag_t'(i)) begin
                busy_d[i] = 1'b1;
            end
            if (ret_vld && ret_tag == tag_t'(i)) begin
                resp_valid_d[i]                  = 1'b1;
                resp_result_d[i*WIDTH +: WIDTH]  = dp_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            dp_valid_q    <= 1'b0;
            dp_a_q        <= '0;
            dp_b_q        <= '0;
            dp_op_q       <= 1'b0;
            rr_ptr_q      <= '0;
            ops_q         <= '0;
            pipe_vld_q    <= '0;
            for (int unsigned s = 0; s < NSTG; s++) begin
                pipe_tag_q[s] <= '0;
            end
        end else begin
            busy_q        <= busy_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            dp_valid_q    <= dp_valid_d;
            dp_a_q        <= dp_a_d;
            dp_b_q        <= dp_b_d;
            dp_op_q       <= dp_op_d;
            rr_ptr_q      <= rr_ptr_d;
            ops_q         <= ops_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_tag_q[0] <= grant_tag;
            for (int unsigned s = 1; s < NSTG; s++) begin
                pipe_tag_q[s] <= pipe_tag_q[s-1];
            end
        end
    end

    assign busy        = busy_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign dp_valid    = dp_valid_q;
    assign dp_a        = dp_a_q;
    assign dp_b        = dp_b_q;
    assign dp_op       = dp_op_q;
    assign ops_issued  = ops_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter: arbitration/busy/latency model plus a result scoreboard.
module tb_fp_addsub_arbiter;

    localparam int unsigned W   = 32;
    localparam int unsigned N   = 2;
    localparam int unsigned LAT = 3;
    localparam int unsigned CW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_op;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready;
    logic [N*W-1:0]   resp_result;
    logic             dp_valid;
    logic [W-1:0]     dp_a;
    logic [W-1:0]     dp_b;
    logic             dp_op;
    logic [W-1:0]     dp_result;
    logic [N-1:0]     busy;
    logic [CW-1:0]    ops_issued;

    always #5 clk = ~clk;

    fp_addsub_arbiter #(
        .WIDTH (W),
        .N_REQ (N),
        .LAT   (LAT),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .dp_valid    (dp_valid),
        .dp_a        (dp_a),
        .dp_b        (dp_b),
        .dp_op       (dp_op),
        .dp_result   (dp_result),
        .busy        (busy),
        .ops_issued  (ops_issued)
    );

    // Datapath stand-in: known IEEE vectors, otherwise an integer add/sub as a traceable tag.
    function automatic logic [W-1:0] dp_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic op);
        if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
        if (a == 32'h40A00000 && b == 32'h3F800000 && op) return 32'h40800000;
        return op ? a - b : a + b;
    endfunction

    logic [W-1:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= dp_f(dp_a, dp_b, dp_op);
        for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
    assign dp_result = dp_pipe[LAT-1];

    typedef struct packed {
        logic [7:0]   tag;
        logic [W-1:0] res;
    } sb_t;

    int           checks = 0;
    int           errors = 0;
    sb_t          sb [$];
    logic [N-1:0] exp_busy = '0;
    int           age [N];
    int           rr_m = 0;
    logic [CW-1:0] exp_ops = '0;
    logic [N-1:0] acc_mask = '0;
    int           n_acc = 0;
    int           n_done0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sb_find(input int t);
        for (int k = 0; k < sb.size(); k++) if (int'(sb[k].tag) == t) return k;
        return -1;
    endfunction

    // One clock: predict/check handshakes before the edge, check registered state after it.
    task automatic tick();
        int           g;
        int           idx;
        int           p;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         eo;
        logic         do_rst;
        logic         acc;
        #1;
        do_rst  = rst;
        g       = -1;
        exp_rdy = '0;
        acc     = 1'b0;
        ea      = '0;
        eb      = '0;
        eo      = 1'b0;
        acc_mask = '0;
        if (!do_rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                if (g < 0 && req_valid[idx] === 1'b1 && !exp_busy[idx]) g = idx;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] === 1'b1 && resp_ready[i] === 1'b1) begin
                    p = sb_find(i);
                    chk("resp_pending", (p >= 0) ? 32'd1 : 32'd0, 32'd1);
                    if (p >= 0) begin
                        chk("resp_result", resp_result[i*W +: W], sb[p].res);
                        sb.delete(p);
                    end
                    exp_busy[i] = 1'b0;
                    if (i == 0) n_done0++;
                end
            end
            if (g >= 0) begin
                acc         = 1'b1;
                acc_mask[g] = 1'b1;
                ea          = req_a[g*W +: W];
                eb          = req_b[g*W +: W];
                eo          = req_op[g];
                sb.push_back('{tag: 8'(g), res: dp_f(ea, eb, eo)});
                exp_busy[g] = 1'b1;
                age[g]      = 0;
                rr_m        = (g + 1) % N;
                exp_ops     = exp_ops + 1'b1;
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            exp_busy = '0;
            rr_m     = 0;
            exp_ops  = '0;
            sb.delete();
            chk("rst_resp_result_lo", resp_result[31:0], 32'd0);
            chk("rst_resp_result_hi", resp_result[63:32], 32'd0);
            chk("rst_dp_a", dp_a, 32'd0);
            chk("rst_dp_b", dp_b, 32'd0);
            chk("rst_dp_op", 32'(dp_op), 32'd0);
        end
        for (int i = 0; i < N; i++) begin
            age[i]++;
            exp_rv[i] = exp_busy[i] && age[i] >= int'(LAT) + 2;
        end
        chk("dp_valid", 32'(dp_valid), 32'(acc));
        if (acc) begin
            chk("dp_a", dp_a, ea);
            chk("dp_b", dp_b, eb);
            chk("dp_op", 32'(dp_op), 32'(eo));
        end
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("ops_issued", 32'(ops_issued), 32'(exp_ops));
        for (int i = 0; i < N; i++) begin
            if (exp_rv[i]) begin
                p = sb_find(i);
                if (p >= 0) chk("resp_hold", resp_result[i*W +: W], sb[p].res);
            end
        end
    endtask

    task automatic new_ops(input int i);
        req_a[i*W +: W] = $urandom;
        req_b[i*W +: W] = $urandom;
        req_op[i]       = 1'($urandom_range(0, 1));
    endtask

    task automatic run_busy(input int n);
        for (int t = 0; t < n; t++) begin
            tick();
            for (int i = 0; i < N; i++) if (acc_mask[i]) new_ops(i);
        end
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = '1;
        for (int t = 0; t < 40 && sb.size() != 0; t++) tick();
        tick();
        chk("drained", 32'(sb.size()), 32'd0);
        resp_ready = '0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Round-robin from reset with immediate consume
        new_ops(0);
        new_ops(1);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        tick();
        chk("rr_first_grant", 32'(acc_mask), 32'd1);
        new_ops(0);
        tick();
        chk("rr_second_grant", 32'(acc_mask), 32'd2);
        new_ops(1);
        run_busy(24);
        drain();

        // Single add op from requester 0
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_op[0]   = 1'b0;
        req_valid   = 2'b01;
        tick();
        req_valid = '0;
        for (int t = 0; t < 6; t++) tick();
        resp_ready = 2'b01;
        tick();
        resp_ready = '0;
        tick();

        // Subtract from requester 1
        req_a[63:32] = 32'h40A00000;
        req_b[63:32] = 32'h3F800000;
        req_op[1]    = 1'b1;
        req_valid    = 2'b10;
        tick();
        req_valid = '0;
        for (int t = 0; t < 5; t++) tick();
        resp_ready = 2'b10;
        tick();
        resp_ready = '0;
        tick();

        // Backpressure on requester 1 while requester 0 keeps cycling
        new_ops(0);
        new_ops(1);
        n_done0    = 0;
        req_valid  = 2'b11;
        resp_ready = 2'b01;
        run_busy(20);
        chk("bp_req0_served", (n_done0 >= 2) ? 32'd1 : 32'd0, 32'd1);
        resp_ready = 2'b11;
        run_busy(3);
        drain();

        // Reset while an op is in flight
        new_ops(0);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 5; t++) tick();

        // First post-reset grant, then counter wrap at 17 accepts
        n_acc      = 0;
        new_ops(0);
        new_ops(1);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        tick();
        chk("grant_after_reset", 32'(acc_mask), 32'd1);
        for (int i = 0; i < N; i++) if (acc_mask[i]) new_ops(i);
        for (int t = 0; t < 300 && n_acc < 17; t++) begin
            tick();
            for (int i = 0; i < N; i++) if (acc_mask[i]) new_ops(i);
        end
        req_valid = '0;
        chk("accepts_17", 32'(n_acc), 32'd17);
        chk("ops_wrap", 32'(ops_issued), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
